// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// No logic of its own; imported by the interface users and the top.
// Holds the FSM state encoding and the hard-wired zero register index.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  // Register index that always reads zero; a load targeting it never creates a dependency.
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle: register specifiers and events in, stage controls out.
// Purely combinational wiring, zero latency.
// No handshake: holds/flushes are level controls applied by the pipeline every cycle.
interface hazard_unit_if #(
  parameter int REG_AW = 5
);

  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              ex_memread_i;
  logic [REG_AW-1:0] ex_rt_i;
  logic              mem_load_i;
  logic              mem_branch_taken_i;

  logic              pc_hold_o;
  logic              ifid_hold_o;
  logic              idex_hold_o;
  logic              exmem_hold_o;
  logic              ifid_flush_o;
  logic              idex_flush_o;
  logic              exmem_flush_o;
  logic              memwb_flush_o;
  logic              busy_o;

  // Pipeline side: drives hazard sources, consumes stage controls.
  modport master (
    output id_rs_i, id_rt_i, ex_memread_i, ex_rt_i, mem_load_i, mem_branch_taken_i,
    input  pc_hold_o, ifid_hold_o, idex_hold_o, exmem_hold_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o, busy_o
  );

  // Hazard unit side.
  modport slave (
    input  id_rs_i, id_rt_i, ex_memread_i, ex_rt_i, mem_load_i, mem_branch_taken_i,
    output pc_hold_o, ifid_hold_o, idex_hold_o, exmem_hold_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o, busy_o
  );

endinterface

// File: rtl/hazard_unit_perf_cnt.sv
// Performance counters for the hazard unit: stall cycles and taken-branch flush events.
// Counts land one cycle after the event (registered); wrap modulo 2^32.
// No backpressure; increments are single-cycle strobes from the hazard unit.
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // Free-running event counters, cleared by synchronous reset, natural wrap on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
      if (flush_inc) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: load-use stall, multi-cycle data-memory wait freeze, taken-branch flush.
// Controls are combinational from inputs and state (same-cycle); wait/flush sequencing is registered.
// Optional HAZARD_UNIT_PERF_EN adds stall/flush event counters; otherwise those ports do not exist.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  hazard_unit_if.slave hz
`ifdef HAZARD_UNIT_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  // The load's entry cycle is itself the first frozen cycle, so the counter only covers the rest.
  localparam int LOAD_INT = (MEM_LAT > 2) ? (MEM_LAT - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_INT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // MEM_LAT=1: no freeze at all. MEM_LAT=2: one frozen cycle, covered by the entry cycle alone.
  localparam bit FREEZE_EN = (MEM_LAT > 1);
  localparam bit WAIT_EN   = (MEM_LAT > 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] zero_reg;
  logic              load_use;
  logic              branch_evt;

  logic pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

  assign zero_reg = REG_AW'(ZERO_REG);

  assign load_use = hz.ex_memread_i && (hz.ex_rt_i != zero_reg) &&
                    ((hz.ex_rt_i == hz.id_rs_i) || (hz.ex_rt_i == hz.id_rt_i));

  assign branch_evt = !rst_i && (state_q == RUN) && hz.mem_branch_taken_i;

  // State and wait counter register; reset aborts any wait or flush sequence.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stage controls; priority in RUN is branch > memory wait > load-use.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        RUN: begin
          if (branch_evt) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = FLUSH;
          end else if (hz.mem_load_i && FREEZE_EN) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_hold  = 1'b1;
            memwb_flush = 1'b1;
            if (WAIT_EN) begin
              cnt_d   = CNT_LOAD;
              state_d = MEM_WAIT;
            end
          end else if (load_use) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_hold   = 1'b1;
          exmem_hold  = 1'b1;
          memwb_flush = 1'b1;
          cnt_d       = (cnt_q != '0) ? (cnt_q - CNT_ONE) : '0;
          // Counter reaches zero as we leave; the next cycle is RUN again.
          if (cnt_q <= CNT_ONE) state_d = RUN;
        end
        FLUSH: begin
          ifid_flush = 1'b1;
          state_d    = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign hz.pc_hold_o     = pc_hold;
  assign hz.ifid_hold_o   = ifid_hold;
  assign hz.idex_hold_o   = idex_hold;
  assign hz.exmem_hold_o  = exmem_hold;
  assign hz.ifid_flush_o  = ifid_flush;
  assign hz.idex_flush_o  = idex_flush;
  assign hz.exmem_flush_o = exmem_flush;
  assign hz.memwb_flush_o = memwb_flush;
  assign hz.busy_o        = !rst_i && (state_q != RUN);

`ifdef HAZARD_UNIT_PERF_EN
  hazard_perf_cnt u_perf (
    .clk       (clk_i),
    .rst       (rst_i),
    .stall_inc (pc_hold),
    .flush_inc (branch_evt),
    .stall_cnt (stall_cnt_o),
    .flush_cnt (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: vector table on a MEM_LAT=3 instance plus
// hand sequences for MEM_LAT=4 (freeze length, reset mid-wait) and MEM_LAT=1.
// All three instances see identical stimulus; each check picks one instance.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memread, mem_load, br_taken;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_unit_if #(.REG_AW(5)) if3 ();
  hazard_unit_if #(.REG_AW(5)) if4 ();
  hazard_unit_if #(.REG_AW(5)) if1 ();

  assign if3.id_rs_i = id_rs;  assign if3.id_rt_i = id_rt;  assign if3.ex_rt_i = ex_rt;
  assign if3.ex_memread_i = ex_memread;  assign if3.mem_load_i = mem_load;
  assign if3.mem_branch_taken_i = br_taken;
  assign if4.id_rs_i = id_rs;  assign if4.id_rt_i = id_rt;  assign if4.ex_rt_i = ex_rt;
  assign if4.ex_memread_i = ex_memread;  assign if4.mem_load_i = mem_load;
  assign if4.mem_branch_taken_i = br_taken;
  assign if1.id_rs_i = id_rs;  assign if1.id_rt_i = id_rt;  assign if1.ex_rt_i = ex_rt;
  assign if1.ex_memread_i = ex_memread;  assign if1.mem_load_i = mem_load;
  assign if1.mem_branch_taken_i = br_taken;

`ifdef HAZARD_UNIT_PERF_EN
  logic [31:0] sc3, fc3, sc4, fc4, sc1, fc1;
`endif

  hazard_unit #(.REG_AW(5), .MEM_LAT(3)) u_dut3 (
    .clk_i (clk), .rst_i (rst), .hz (if3.slave)
`ifdef HAZARD_UNIT_PERF_EN
    , .stall_cnt_o (sc3), .flush_cnt_o (fc3)
`endif
  );
  hazard_unit #(.REG_AW(5), .MEM_LAT(4)) u_dut4 (
    .clk_i (clk), .rst_i (rst), .hz (if4.slave)
`ifdef HAZARD_UNIT_PERF_EN
    , .stall_cnt_o (sc4), .flush_cnt_o (fc4)
`endif
  );
  hazard_unit #(.REG_AW(5), .MEM_LAT(1)) u_dut1 (
    .clk_i (clk), .rst_i (rst), .hz (if1.slave)
`ifdef HAZARD_UNIT_PERF_EN
    , .stall_cnt_o (sc1), .flush_cnt_o (fc1)
`endif
  );

  // Output order: pc_h ifid_h idex_h exmem_h | ifid_f idex_f exmem_f memwb_f | busy
  logic [8:0] o3, o4, o1;
  assign o3 = {if3.pc_hold_o, if3.ifid_hold_o, if3.idex_hold_o, if3.exmem_hold_o,
               if3.ifid_flush_o, if3.idex_flush_o, if3.exmem_flush_o, if3.memwb_flush_o, if3.busy_o};
  assign o4 = {if4.pc_hold_o, if4.ifid_hold_o, if4.idex_hold_o, if4.exmem_hold_o,
               if4.ifid_flush_o, if4.idex_flush_o, if4.exmem_flush_o, if4.memwb_flush_o, if4.busy_o};
  assign o1 = {if1.pc_hold_o, if1.ifid_hold_o, if1.idex_hold_o, if1.exmem_hold_o,
               if1.ifid_flush_o, if1.idex_flush_o, if1.exmem_flush_o, if1.memwb_flush_o, if1.busy_o};

  localparam logic [8:0] IDLE  = 9'b0000_0000_0;
  localparam logic [8:0] LU    = 9'b1100_0100_0;
  localparam logic [8:0] MENT  = 9'b1111_0001_0;
  localparam logic [8:0] MWAIT = 9'b1111_0001_1;
  localparam logic [8:0] BR0   = 9'b0000_1110_0;
  localparam logic [8:0] BR1   = 9'b0000_1000_1;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       rd;
    logic [4:0] exrt;
    logic       ld, br;
    logic [8:0] exp;
    string      name;
  } vec_t;

  function automatic vec_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic rd,
                              logic [4:0] exrt, logic ld, logic br, logic [8:0] exp, string name);
    vec_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.rd = rd; v.exrt = exrt;
    v.ld = ld; v.br = br; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic overlap(logic [8:0] v);
    return (v[7] & v[4]) | (v[6] & v[3]) | (v[5] & v[2]);
  endfunction

  // Called at posedge+1: drive, sample at the falling edge, advance to next posedge+1.
  task automatic step(vec_t v, int sel);
    logic [8:0] act;
    rst = v.rst; id_rs = v.rs; id_rt = v.rt; ex_memread = v.rd;
    ex_rt = v.exrt; mem_load = v.ld; br_taken = v.br;
    #4;
    act = (sel == 4) ? o4 : (sel == 1) ? o1 : o3;
    check(v.name, {23'd0, act}, {23'd0, v.exp});
    check({v.name, "_hold_vs_flush"}, {31'd0, overlap(act)}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  vec_t tbl[24];

  initial begin
    tbl[0]  = mk(1, 8, 0, 1, 8, 1, 1, IDLE,  "reset_gates_outputs");
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, IDLE,  "reset_idle");
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, IDLE,  "after_reset_run");
    tbl[3]  = mk(0, 8, 0, 1, 8, 0, 0, LU,    "load_use_rs");
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, IDLE,  "load_use_released");
    tbl[5]  = mk(0, 3, 8, 1, 8, 0, 0, LU,    "load_use_rt");
    tbl[6]  = mk(0, 0, 0, 1, 0, 0, 0, IDLE,  "load_use_zero_reg");
    tbl[7]  = mk(0, 8, 8, 0, 8, 0, 0, IDLE,  "no_memread");
    tbl[8]  = mk(0, 8, 7, 1, 9, 0, 0, IDLE,  "no_reg_match");
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, MENT,  "mem_wait_entry");
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, MWAIT, "mem_wait_cycle");
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, IDLE,  "mem_wait_done");
    tbl[12] = mk(0, 8, 0, 1, 8, 1, 0, MENT,  "load_beats_load_use");
    tbl[13] = mk(0, 8, 0, 1, 8, 0, 1, MWAIT, "mem_wait_ignores_inputs");
    tbl[14] = mk(0, 8, 0, 1, 8, 0, 0, LU,    "load_use_reevaluated");
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, BR0,   "branch_cycle0");
    tbl[16] = mk(0, 8, 0, 1, 8, 1, 0, BR1,   "flush_ignores_inputs");
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, IDLE,  "branch_cycle2");
    tbl[18] = mk(0, 8, 0, 1, 8, 1, 1, BR0,   "branch_beats_all");
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, BR1,   "branch_no_mem_wait");
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, IDLE,  "branch_all_low");
    tbl[21] = mk(0, 0, 0, 0, 0, 1, 0, MENT,  "entry_before_reset");
    tbl[22] = mk(1, 0, 0, 0, 0, 0, 0, IDLE,  "reset_in_mem_wait");
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, IDLE,  "reset_aborted_wait");

    rst = 1'b1; id_rs = '0; id_rt = '0; ex_rt = '0;
    ex_memread = 1'b0; mem_load = 1'b0; br_taken = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) step(tbl[i], 3);

    // MEM_LAT=4: three frozen cycles, two of them busy.
    step(mk(1, 0, 0, 0, 0, 0, 0, IDLE,  "l4_reset"), 4);
    step(mk(0, 0, 0, 0, 0, 1, 0, MENT,  "l4_entry"), 4);
    step(mk(0, 0, 0, 0, 0, 0, 0, MWAIT, "l4_wait1"), 4);
    step(mk(0, 0, 0, 0, 0, 0, 0, MWAIT, "l4_wait2"), 4);
    step(mk(0, 0, 0, 0, 0, 0, 0, IDLE,  "l4_run"), 4);
    // MEM_LAT=4: reset in the second MEM_WAIT cycle.
    step(mk(0, 0, 0, 0, 0, 1, 0, MENT,  "l4r_entry"), 4);
    step(mk(0, 0, 0, 0, 0, 0, 0, MWAIT, "l4r_wait1"), 4);
    step(mk(1, 0, 0, 0, 0, 0, 0, IDLE,  "l4r_reset_wait2"), 4);
    step(mk(0, 0, 0, 0, 0, 0, 0, IDLE,  "l4r_after_reset"), 4);

    // MEM_LAT=1: a load causes no freeze.
    step(mk(0, 0, 0, 0, 0, 1, 0, IDLE,  "l1_load_ignored"), 1);
    step(mk(0, 0, 0, 0, 0, 0, 0, IDLE,  "l1_still_run"), 1);

`ifdef HAZARD_UNIT_PERF_EN
    step(mk(1, 0, 0, 0, 0, 0, 0, IDLE, "perf_reset"), 3);
    check("perf_stall_cleared", sc3, 32'd0);
    check("perf_flush_cleared", fc3, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(mk(0, 8, 0, 1, 8, 0, 0, LU,   "perf_lu"), 3);
      step(mk(0, 0, 0, 0, 0, 0, 0, IDLE, "perf_gap"), 3);
    end
    step(mk(0, 0, 0, 0, 0, 0, 1, BR0,  "perf_br0"), 3);
    step(mk(0, 0, 0, 0, 0, 0, 0, BR1,  "perf_br1"), 3);
    check("perf_stall_cnt", sc3, 32'd3);
    check("perf_flush_cnt", fc3, 32'd1);
    force u_dut3.u_perf.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release u_dut3.u_perf.stall_cnt;
    step(mk(0, 8, 0, 1, 8, 0, 0, LU, "perf_wrap_lu"), 3);
    check("perf_stall_wrap", sc3, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
